// File: rtl/ripple_ide_pkg.sv
// Shared types and address-map constants for the Zorro II multi-channel IDE controller.
package ripple_ide_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        STROBE  = 3'd2,
        ACK     = 3'd3,
        RECOVER = 3'd4,
        ROM     = 3'd5
    } ide_state_e;

    localparam int IDE_SEL_BIT  = 15;
    localparam int CHAN_LSB     = 13;
    localparam int CS_SEL_BIT   = 12;
    localparam int MAX_CHANNELS = 4;
    localparam int TIMER_W      = $clog2(16);

    function automatic logic [MAX_CHANNELS-1:0] chan_onehot(input logic [1:0] chan);
        logic [MAX_CHANNELS-1:0] one;
        one = MAX_CHANNELS'(1);
        return one << chan;
    endfunction

endpackage

// File: rtl/ide_strobe_timer.sv
// Shared phase counter: loads N-1 on state entry, counts down, flags done at zero.
module ide_strobe_timer
    import ripple_ide_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    output logic               done
);

    logic [TIMER_W-1:0] cnt_q;
    logic [TIMER_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - TIMER_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/ide_multi_ctrl.sv
// Zorro II IDE bus-cycle sequencer for up to four ATA channels; optional boot-ROM
// window compiled in with `define IDE_ROM_EN.
//
//   state   | meaning
//   IDLE    | waiting for a fresh, enabled, decoded 68000 data strobe
//   SETUP   | CS and buffer enable asserted, strobes idle
//   STROBE  | IOR_n or IOW_n low
//   ACK     | DTACK high until AS_n returns high
//   RECOVER | everything inactive before the next cycle may start
//   ROM     | boot-ROM read: ROMEN, then DTACK, until AS_n returns high
module ide_multi_ctrl
    import ripple_ide_pkg::*;
#(
    parameter int CHANNELS      = 2,
    parameter int SETUP_CLKS    = 1,
    parameter int STROBE_CLKS   = 3,
    parameter int RECOVERY_CLKS = 1
) (
    input  logic                CLK,
    input  logic                RESET_n,
    input  logic [23:1]         ADDR,
    input  logic                AS_n,
    input  logic                UDS_n,
    input  logic                LDS_n,
    input  logic                RW,
    input  logic                BERR_n,
    input  logic                ide_access,
    input  logic                ide_enable,
    output logic                DTACK,
    output logic                IOR_n,
    output logic                IOW_n,
    output logic [CHANNELS-1:0] IDECS1_n,
    output logic [CHANNELS-1:0] IDECS2_n,
    output logic                IDEBUF_OE,
    output logic                IDE_ROMEN,
    output logic                busy
);

    localparam logic [TIMER_W-1:0] SETUP_LD    = TIMER_W'(SETUP_CLKS - 1);
    localparam logic [TIMER_W-1:0] STROBE_LD   = TIMER_W'(STROBE_CLKS - 1);
    localparam logic [TIMER_W-1:0] RECOVERY_LD = TIMER_W'(RECOVERY_CLKS - 1);
    localparam ide_state_e         REC_TARGET  = (RECOVERY_CLKS == 0) ? IDLE : RECOVER;

    ide_state_e state_q, state_d;

    logic [1:0]          chan_q, chan_d;
    logic                cs2_q, cs2_d;
    logic                rw_q, rw_d;
    logic                valid_q, valid_d;
    logic                as_armed_q, as_armed_d;

    logic                dtack_q, dtack_d;
    logic                ior_n_q, ior_n_d;
    logic                iow_n_q, iow_n_d;
    logic [CHANNELS-1:0] cs1_n_q, cs1_n_d;
    logic [CHANNELS-1:0] cs2_n_q, cs2_n_d;
    logic                oe_q, oe_d;
    logic                romen_q, romen_d;
    logic                busy_q, busy_d;

    logic                start;
    logic                tmr_load;
    logic [TIMER_W-1:0]  tmr_val;
    logic                tmr_done;
    logic                act;
    logic [MAX_CHANNELS-1:0] sel_onehot;

    // Only the window-internal decode bits are used.
    logic unused_addr;
    assign unused_addr = ^{ADDR[23:16], ADDR[15], ADDR[11:1]};

    ide_strobe_timer u_timer (
        .clk      (CLK),
        .rst_n    (RESET_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // A start needs AS_n to have been seen high since the last start, so a
    // cycle aborted by BERR or reset never re-runs on the same AS_n assertion.
    assign start = !AS_n && ide_access && ide_enable && (!UDS_n || !LDS_n) && as_armed_q;

    always_comb begin
        state_d    = state_q;
        chan_d     = chan_q;
        cs2_d      = cs2_q;
        rw_d       = rw_q;
        valid_d    = valid_q;
        as_armed_d = AS_n ? 1'b1 : as_armed_q;
        tmr_load   = 1'b0;
        tmr_val    = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    as_armed_d = 1'b0;
                    chan_d     = ADDR[CHAN_LSB +: 2];
                    cs2_d      = ADDR[CS_SEL_BIT];
                    rw_d       = RW;
                    valid_d    = (32'(ADDR[CHAN_LSB +: 2]) < CHANNELS);
                    state_d    = SETUP;
`ifdef IDE_ROM_EN
                    if (!ADDR[IDE_SEL_BIT]) begin
                        valid_d = 1'b0;
                        if (RW) begin
                            state_d = ROM;
                        end
                    end
`endif
                end
            end
            SETUP: begin
                if (!BERR_n || AS_n) begin
                    state_d = REC_TARGET;
                end else if (tmr_done) begin
                    state_d = STROBE;
                end
            end
            STROBE: begin
                if (!BERR_n || AS_n) begin
                    state_d = REC_TARGET;
                end else if (tmr_done) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                if (!BERR_n || AS_n) begin
                    state_d = REC_TARGET;
                end
            end
            RECOVER: begin
                if (tmr_done) begin
                    state_d = IDLE;
                end
            end
`ifdef IDE_ROM_EN
            ROM: begin
                if (!BERR_n) begin
                    state_d = REC_TARGET;
                end else if (AS_n) begin
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) begin
            case (state_d)
                SETUP:   begin tmr_load = 1'b1; tmr_val = SETUP_LD;    end
                STROBE:  begin tmr_load = 1'b1; tmr_val = STROBE_LD;   end
                RECOVER: begin tmr_load = 1'b1; tmr_val = RECOVERY_LD; end
                default: ;
            endcase
        end
    end

    // Outputs are decoded from the next state so each flop changes on the
    // same edge as the state it belongs to.
    always_comb begin
        sel_onehot = chan_onehot(chan_d);
        act        = valid_d && ((state_d == SETUP) || (state_d == STROBE) || (state_d == ACK));
        cs1_n_d    = ~((act && !cs2_d) ? sel_onehot[CHANNELS-1:0] : {CHANNELS{1'b0}});
        cs2_n_d    = ~((act &&  cs2_d) ? sel_onehot[CHANNELS-1:0] : {CHANNELS{1'b0}});
        oe_d       = act;
        ior_n_d    = !(valid_d && rw_d && ((state_d == STROBE) || (state_d == ACK)));
        iow_n_d    = !(valid_d && !rw_d && (state_d == STROBE));
        busy_d     = (state_d != IDLE);
`ifdef IDE_ROM_EN
        romen_d    = (state_d == ROM) && (state_q == ROM);
        dtack_d    = (state_d == ACK) || ((state_d == ROM) && romen_q);
`else
        romen_d    = 1'b0;
        dtack_d    = (state_d == ACK);
`endif
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q    <= IDLE;
            chan_q     <= '0;
            cs2_q      <= 1'b0;
            rw_q       <= 1'b1;
            valid_q    <= 1'b0;
            as_armed_q <= 1'b0;
            dtack_q    <= 1'b0;
            ior_n_q    <= 1'b1;
            iow_n_q    <= 1'b1;
            cs1_n_q    <= '1;
            cs2_n_q    <= '1;
            oe_q       <= 1'b0;
            romen_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            chan_q     <= chan_d;
            cs2_q      <= cs2_d;
            rw_q       <= rw_d;
            valid_q    <= valid_d;
            as_armed_q <= as_armed_d;
            dtack_q    <= dtack_d;
            ior_n_q    <= ior_n_d;
            iow_n_q    <= iow_n_d;
            cs1_n_q    <= cs1_n_d;
            cs2_n_q    <= cs2_n_d;
            oe_q       <= oe_d;
            romen_q    <= romen_d;
            busy_q     <= busy_d;
        end
    end

    assign DTACK     = dtack_q;
    assign IOR_n     = ior_n_q;
    assign IOW_n     = iow_n_q;
    assign IDECS1_n  = cs1_n_q;
    assign IDECS2_n  = cs2_n_q;
    assign IDEBUF_OE = oe_q;
    assign IDE_ROMEN = romen_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_ide_multi_ctrl.sv
// Directed bench for ide_multi_ctrl: a default instance and a 4-channel, 5-clock-strobe
// instance share one stimulus bus.
module tb_ide_multi_ctrl;

    logic        clk;
    logic        rst_n;
    logic [23:1] addr;
    logic        as_n, uds_n, lds_n, rw, berr_n, ide_access, ide_enable;

    logic       a_dtack, a_ior_n, a_iow_n, a_oe, a_romen, a_busy;
    logic [1:0] a_cs1_n, a_cs2_n;
    logic       b_dtack, b_ior_n, b_iow_n, b_oe, b_romen, b_busy;
    logic [3:0] b_cs1_n, b_cs2_n;

    int n_checks = 0;
    int n_errors = 0;

    ide_multi_ctrl u_dut_a (
        .CLK(clk), .RESET_n(rst_n), .ADDR(addr), .AS_n(as_n), .UDS_n(uds_n), .LDS_n(lds_n),
        .RW(rw), .BERR_n(berr_n), .ide_access(ide_access), .ide_enable(ide_enable),
        .DTACK(a_dtack), .IOR_n(a_ior_n), .IOW_n(a_iow_n), .IDECS1_n(a_cs1_n),
        .IDECS2_n(a_cs2_n), .IDEBUF_OE(a_oe), .IDE_ROMEN(a_romen), .busy(a_busy)
    );

    ide_multi_ctrl #(.CHANNELS(4), .SETUP_CLKS(1), .STROBE_CLKS(5), .RECOVERY_CLKS(1)) u_dut_b (
        .CLK(clk), .RESET_n(rst_n), .ADDR(addr), .AS_n(as_n), .UDS_n(uds_n), .LDS_n(lds_n),
        .RW(rw), .BERR_n(berr_n), .ide_access(ide_access), .ide_enable(ide_enable),
        .DTACK(b_dtack), .IOR_n(b_ior_n), .IOW_n(b_iow_n), .IDECS1_n(b_cs1_n),
        .IDECS2_n(b_cs2_n), .IDEBUF_OE(b_oe), .IDE_ROMEN(b_romen), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a cycle and returns just after the edge E that samples it.
    task automatic start_cycle(input logic [23:0] full_addr, input logic rd);
        logic [23:0] a;
        a          = full_addr;
        addr       = a[23:1];
        rw         = rd;
        ide_access = 1'b1;
        as_n       = 1'b0;
        uds_n      = 1'b0;
        lds_n      = rd ? 1'b1 : 1'b0;
        tick();
    endtask

    task automatic end_cycle();
        as_n       = 1'b1;
        uds_n      = 1'b1;
        lds_n      = 1'b1;
        ide_access = 1'b0;
    endtask

    initial begin
        int  lowcnt;
        int  dt_at;
        logic any_act;
        logic any_dt;

        rst_n = 1'b0; addr = '0; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
        rw = 1'b1; berr_n = 1'b1; ide_access = 1'b0; ide_enable = 1'b1;
        tick(); tick();
        check_val("rst_dtack", 32'(a_dtack), 0);
        check_val("rst_ior",   32'(a_ior_n), 1);
        check_val("rst_iow",   32'(a_iow_n), 1);
        check_val("rst_cs1",   32'(a_cs1_n), 32'h3);
        check_val("rst_cs2",   32'(a_cs2_n), 32'h3);
        check_val("rst_oe",    32'(a_oe), 0);
        check_val("rst_romen", 32'(a_romen), 0);
        check_val("rst_busy",  32'(a_busy), 0);
        rst_n = 1'b1;
        tick(); tick();

        // Read, channel 0, CS1
        start_cycle(24'hE98000, 1'b1);
        check_val("rd_cs1_e",   32'(a_cs1_n), 32'h2);
        check_val("rd_cs2_e",   32'(a_cs2_n), 32'h3);
        check_val("rd_b_cs1_e", 32'(b_cs1_n), 32'hE);
        check_val("rd_ior_e",   32'(a_ior_n), 1);
        check_val("rd_oe_e",    32'(a_oe), 1);
        check_val("rd_busy_e",  32'(a_busy), 1);
        tick();
        check_val("rd_ior_e1",  32'(a_ior_n), 0);
        check_val("rd_iow_e1",  32'(a_iow_n), 1);
        tick(); tick();
        check_val("rd_dtack_e3", 32'(a_dtack), 0);
        tick();
        check_val("rd_dtack_e4", 32'(a_dtack), 1);
        check_val("rd_ior_e4",   32'(a_ior_n), 0);
        check_val("rd_cs1_e4",   32'(a_cs1_n), 32'h2);
        tick();
        check_val("rd_dtack_hold", 32'(a_dtack), 1);
        check_val("rd_b_dtack_e5", 32'(b_dtack), 0);
        end_cycle();
        tick();
        check_val("rd_dtack_f",  32'(a_dtack), 0);
        check_val("rd_ior_f",    32'(a_ior_n), 1);
        check_val("rd_cs1_f",    32'(a_cs1_n), 32'h3);
        check_val("rd_oe_f",     32'(a_oe), 0);
        check_val("rd_busy_f",   32'(a_busy), 1);
        check_val("abort_b_dt",  32'(b_dtack), 0);
        check_val("abort_b_ior", 32'(b_ior_n), 1);
        tick();
        check_val("rd_busy_f1",  32'(a_busy), 0);
        check_val("abort_b_busy", 32'(b_busy), 0);

        // Write, channel 1, CS2, 5-clock strobe on instance B
        start_cycle(24'hE9B000, 1'b0);
        check_val("wr_b_cs2_e", 32'(b_cs2_n), 32'hD);
        check_val("wr_b_cs1_e", 32'(b_cs1_n), 32'hF);
        check_val("wr_a_cs2_e", 32'(a_cs2_n), 32'h1);
        check_val("wr_b_iow_e", 32'(b_iow_n), 1);
        lowcnt = 0;
        dt_at  = -1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (b_iow_n == 1'b0) lowcnt++;
            if (b_dtack && dt_at < 0) dt_at = k;
            if (dt_at >= 0) break;
        end
        check_val("wr_b_dtack_at", 32'(dt_at), 6);
        check_val("wr_b_iow_len",  32'(lowcnt), 5);
        check_val("wr_b_iow_ack",  32'(b_iow_n), 1);
        check_val("wr_a_dtack",    32'(a_dtack), 1);
        end_cycle();
        tick();
        check_val("wr_b_dtack_f", 32'(b_dtack), 0);
        check_val("wr_b_busy_f",  32'(b_busy), 1);
        tick();
        check_val("wr_b_busy_f1", 32'(b_busy), 0);

        // Null cycle: channel 3 on the 2-channel instance
        start_cycle(24'hE9E000, 1'b1);
        check_val("null_b_cs1_e", 32'(b_cs1_n), 32'h7);
        any_act = (a_cs1_n != 2'b11) || (a_cs2_n != 2'b11) || !a_ior_n || !a_iow_n || a_oe;
        dt_at = -1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            any_act |= (a_cs1_n != 2'b11) || (a_cs2_n != 2'b11) || !a_ior_n || !a_iow_n || a_oe;
            if (a_dtack && dt_at < 0) dt_at = k;
        end
        check_val("null_dtack_at", 32'(dt_at), 4);
        check_val("null_quiet",    32'(any_act), 0);
        end_cycle();
        tick(); tick(); tick();

        // Bus error during STROBE
        start_cycle(24'hE98000, 1'b1);
        tick();
        check_val("berr_ior_pre", 32'(a_ior_n), 0);
        berr_n = 1'b0;
        tick();
        check_val("berr_ior",   32'(a_ior_n), 1);
        check_val("berr_dtack", 32'(a_dtack), 0);
        check_val("berr_busy",  32'(a_busy), 1);
        check_val("berr_cs1",   32'(a_cs1_n), 32'h3);
        berr_n = 1'b1;
        any_dt = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            any_dt |= a_dtack | b_dtack;
        end
        check_val("berr_no_dtack", 32'(any_dt), 0);
        check_val("berr_no_rerun", 32'(a_busy), 0);
        end_cycle();
        tick(); tick();

        // Asynchronous reset in the middle of STROBE
        start_cycle(24'hE98000, 1'b1);
        tick();
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_ior",   32'(a_ior_n), 1);
        check_val("arst_cs1",   32'(a_cs1_n), 32'h3);
        check_val("arst_busy",  32'(a_busy), 0);
        check_val("arst_oe",    32'(a_oe), 0);
        check_val("arst_dtack", 32'(a_dtack), 0);
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();
        check_val("arst_no_start", 32'(a_busy), 0);
        as_n = 1'b1;
        tick();
        as_n = 1'b0;
        tick();
        check_val("arst_fresh_busy", 32'(a_busy), 1);
        check_val("arst_fresh_cs1",  32'(a_cs1_n), 32'h2);
        tick(); tick(); tick(); tick();
        check_val("arst_fresh_dtack", 32'(a_dtack), 1);
        end_cycle();
        tick(); tick(); tick();

        // ide_enable low blocks a new cycle
        ide_enable = 1'b0;
        start_cycle(24'hE98000, 1'b1);
        tick(); tick();
        check_val("dis_busy",  32'(a_busy), 0);
        check_val("dis_dtack", 32'(a_dtack), 0);
        check_val("dis_cs1",   32'(a_cs1_n), 32'h3);
        end_cycle();
        ide_enable = 1'b1;
        tick();

`ifdef IDE_ROM_EN
        start_cycle(24'hE90000, 1'b1);
        check_val("rom_romen_e", 32'(a_romen), 0);
        check_val("rom_busy_e",  32'(a_busy), 1);
        check_val("rom_cs1_e",   32'(a_cs1_n), 32'h3);
        check_val("rom_oe_e",    32'(a_oe), 0);
        tick();
        check_val("rom_romen_e1", 32'(a_romen), 1);
        check_val("rom_dtack_e1", 32'(a_dtack), 0);
        tick();
        check_val("rom_dtack_e2", 32'(a_dtack), 1);
        check_val("rom_ior_e2",   32'(a_ior_n), 1);
        end_cycle();
        tick();
        check_val("rom_romen_f", 32'(a_romen), 0);
        check_val("rom_dtack_f", 32'(a_dtack), 0);
        check_val("rom_busy_f",  32'(a_busy), 0);
        tick(); tick(); tick();
        ide_enable = 1'b0;
        start_cycle(24'hE90000, 1'b1);
        tick(); tick();
        check_val("rom_dis_busy",  32'(a_busy), 0);
        check_val("rom_dis_romen", 32'(a_romen), 0);
        end_cycle();
        ide_enable = 1'b1;
        tick();
`else
        start_cycle(24'hE90000, 1'b1);
        check_val("norom_cs1_e",   32'(a_cs1_n), 32'h2);
        check_val("norom_romen_e", 32'(a_romen), 0);
        tick(); tick(); tick(); tick();
        check_val("norom_dtack", 32'(a_dtack), 1);
        check_val("norom_romen", 32'(a_romen), 0);
        end_cycle();
        tick(); tick(); tick();
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
